// File: rtl/fifo_frame_reader_if.sv
// FIFO read port and framed output stream of fifo_frame_reader.
// master = the reader block, slave = FIFO plus downstream egress logic.
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_data_valid;
  logic [DATA_WIDTH-1:0] stream_data;
  logic                  stream_valid;
  logic                  stream_last;
  logic                  stream_ready;

  modport master (
    input  fifo_empty, fifo_read_data, fifo_read_data_valid, stream_ready,
    output fifo_read_enable, stream_data, stream_valid, stream_last
  );

  modport slave (
    output fifo_empty, fifo_read_data, fifo_read_data_valid, stream_ready,
    input  fifo_read_enable, stream_data, stream_valid, stream_last
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drains a 1-cycle-latency FIFO into a framed valid/ready stream, dropping oversized frames.
// Optional FIFO_FRAME_READER_FRAME_COUNT_EN adds saturating frame_count / drop_count outputs.
module fifo_frame_reader #(
  parameter int          DATA_WIDTH      = 16,
  parameter int          LENGTH_WIDTH    = 12,
  parameter int unsigned MAX_FRAME_WORDS = 1024
) (
  input  logic                clock,
  input  logic                reset,
  fifo_frame_reader_if.master bus,
  output logic                frame_error,
  output logic                busy
`ifdef FIFO_FRAME_READER_FRAME_COUNT_EN
  ,
  output logic [31:0]         frame_count,
  output logic [15:0]         drop_count
`endif
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_e;

  state_e                         state_q, state_d, cur_state;
  logic [LENGTH_WIDTH-1:0]        cnt_q, cnt_d;
  logic [1:0][DATA_WIDTH-1:0]     buf_q, buf_d;
  logic [1:0]                     count_q, count_d;
  logic                           in_flight_q, in_flight_d;
  logic                           frame_error_q, frame_error_d;

  logic                           rd_vld, head_vld, pop, store, out_valid, out_last;
  logic [DATA_WIDTH-1:0]          head;
  logic [LENGTH_WIDTH-1:0]        hdr_len;
  logic [1:0]                     fill;

  // An empty buffer lets the arriving word flow straight to the head, which
  // is what keeps one word per cycle under the fill < 2 read rule.
  assign rd_vld   = bus.fifo_read_data_valid && !reset;
  assign head_vld = !reset && (count_q != 2'd0 || rd_vld);
  assign head     = (count_q != 2'd0) ? buf_q[0] : bus.fifo_read_data;
  assign hdr_len  = head[LENGTH_WIDTH-1:0];
  assign fill     = count_q + {1'b0, in_flight_q};

  assign bus.fifo_read_enable = !reset && !bus.fifo_empty && (fill < 2'd2);
  assign bus.stream_valid     = out_valid;
  assign bus.stream_last      = out_last;
  assign bus.stream_data      = out_valid ? head : '0;
  assign frame_error          = frame_error_q;
  assign busy                 = (state_q != IDLE) || (count_q != 2'd0) || in_flight_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    frame_error_d = 1'b0;
    cur_state     = (state_q == IDLE && head_vld) ? HEADER : state_q;
    case (cur_state)
      HEADER: if (head_vld) begin
        if (32'(hdr_len) > MAX_FRAME_WORDS) begin
          pop           = 1'b1;
          frame_error_d = 1'b1;
          cnt_d         = hdr_len;
          state_d       = DROP;
        end else begin
          out_valid = 1'b1;
          out_last  = (hdr_len == '0);
          state_d   = HEADER;
          if (bus.stream_ready) begin
            pop     = 1'b1;
            cnt_d   = hdr_len;
            state_d = (hdr_len == '0) ? IDLE : PAYLOAD;
          end
        end
      end
      PAYLOAD: if (head_vld) begin
        out_valid = 1'b1;
        out_last  = (cnt_q == LENGTH_WIDTH'(1));
        if (bus.stream_ready) begin
          pop   = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LENGTH_WIDTH'(1)) state_d = IDLE;
        end
      end
      DROP: if (head_vld) begin
        pop   = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LENGTH_WIDTH'(1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    store   = rd_vld && !(count_q == 2'd0 && pop);
    if (pop && count_q != 2'd0) begin
      buf_d[0] = buf_q[1];
      count_d  = count_q - 2'd1;
    end
    if (store) begin
      buf_d[count_d[0]] = bus.fifo_read_data;
      count_d           = count_d + 2'd1;
    end
    in_flight_d = bus.fifo_read_enable ? 1'b1 : (rd_vld ? 1'b0 : in_flight_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      buf_q         <= '0;
      count_q       <= '0;
      in_flight_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      count_q       <= count_d;
      in_flight_q   <= in_flight_d;
      frame_error_q <= frame_error_d;
    end
  end

`ifdef FIFO_FRAME_READER_FRAME_COUNT_EN
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if (out_valid && bus.stream_ready && out_last && frame_count_q != '1)
      frame_count_d = frame_count_q + 32'd1;
    if (frame_error_q && drop_count_q != '1)
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif
endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: queue-based FIFO model and frame-level scoreboard.
module tb_fifo_frame_reader;
  localparam int DW   = 16;
  localparam int LW   = 12;
  localparam int MAXW = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_error, busy;
`ifdef FIFO_FRAME_READER_FRAME_COUNT_EN
  logic [31:0] frame_count;
  logic [15:0] drop_count;
`endif

  fifo_frame_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_frame_reader #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .MAX_FRAME_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .bus(bus), .frame_error(frame_error), .busy(busy)
`ifdef FIFO_FRAME_READER_FRAME_COUNT_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  always #5 clock = ~clock;

  // FIFO model: 1-cycle read latency, flushed by reset.
  logic [DW-1:0] mem [0:8191];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            nreads = 0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_vld  = 1'b0;

  assign bus.fifo_empty           = (rd_ptr == wr_ptr);
  assign bus.fifo_read_data       = rd_data;
  assign bus.fifo_read_data_valid = rd_vld;

  always @(posedge clock) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_ptr <= wr_ptr;
    end else begin
      rd_vld <= bus.fifo_read_enable;
      if (bus.fifo_read_enable) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1;
        nreads  <= nreads + 1;
      end
    end
  end

  // Reference model: expected {last,data} words and expected drop pulses.
  logic [16:0]   exp_q [$];
  logic [DW-1:0] pl_q  [$];
  logic [DW-1:0] pend_q[$];
  int exp_err = 0;
  int total = 0, bad = 0, xfers = 0;

  task automatic fifo_write(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic fill_rand(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(DW'($urandom));
  endtask

  // Writes header plus the first nwrite payload words of pl_q; the rest wait in pend_q.
  task automatic add_frame(input logic [DW-1:0] hdr, input int nwrite);
    int n;
    n = int'(hdr[LW-1:0]);
    fifo_write(hdr);
    for (int i = 0; i < pl_q.size(); i++)
      if (i < nwrite) fifo_write(pl_q[i]); else pend_q.push_back(pl_q[i]);
    if (n > MAXW) exp_err++;
    else begin
      exp_q.push_back({n == 0, hdr});
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, pl_q[i]});
    end
  endtask

  task automatic flush_pend();
    while (pend_q.size() > 0) fifo_write(pend_q.pop_front());
  endtask

  // mode 0: ready=1, 1: toggle, 2: random.
  task automatic run_stream(input int mode, input int max_cyc, input bit chk_gap, input bit chk_occ);
    int off, errs, last_x;
    bit pv, pr, r, done;
    logic [DW-1:0] pd;
    logic pl;
    logic [16:0] e;
    off = nreads - xfers; errs = 0; last_x = -1;
    pv = 0; pr = 0; pd = '0; pl = 0; done = 0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clock);
      if (frame_error) errs++;
      if (pv && !pr) begin
        total++;
        if (bus.stream_valid !== 1'b1 || bus.stream_data !== pd || bus.stream_last !== pl) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   bus.stream_valid, bus.stream_data, bus.stream_last, pd, pl);
        end
      end
      if (chk_occ && bus.fifo_read_enable) begin
        total++;
        if (nreads - xfers - off >= 2) begin
          bad++;
          $display("FAIL occupancy: read issued with %0d held, need < 2", nreads - xfers - off);
        end
      end
      if (exp_q.size() == 0 && !busy && !bus.stream_valid && bus.fifo_empty) done = 1;
      else begin
        case (mode)
          0:       r = 1'b1;
          1:       r = cyc[0];
          default: r = 1'($urandom_range(0, 1));
        endcase
        bus.stream_ready = r;
        if (bus.stream_valid && r) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_word: got l=%b d=%h, need none", bus.stream_last, bus.stream_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.stream_last, bus.stream_data} !== e) begin
              bad++;
              $display("FAIL word: got l=%b d=%h, need l=%b d=%h",
                       bus.stream_last, bus.stream_data, e[16], e[15:0]);
            end
          end
          if (chk_gap && last_x >= 0) begin
            total++;
            if (cyc != last_x + 1) begin
              bad++;
              $display("FAIL gap: transfer at cycle %0d, need %0d", cyc, last_x + 1);
            end
          end
          last_x = cyc;
          xfers++;
        end
        pv = bus.stream_valid; pr = r; pd = bus.stream_data; pl = bus.stream_last;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout: %0d words pending busy=%b, need 0 and idle", exp_q.size(), busy);
    end
    total++;
    if (errs != exp_err) begin
      bad++;
      $display("FAIL frame_error_count: got %0d, need %0d", errs, exp_err);
    end
    exp_err = 0;
    exp_q.delete();
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (bus.stream_valid !== 1'b0 || bus.stream_last !== 1'b0 || bus.stream_data !== '0 ||
        bus.fifo_read_enable !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: got v=%b l=%b d=%h en=%b err=%b busy=%b, need all 0", name,
               bus.stream_valid, bus.stream_last, bus.stream_data, bus.fifo_read_enable,
               frame_error, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stream_ready = 1'b0;
    repeat (3) @(negedge clock);
    fifo_write(16'h0003);
    #1;
    total++;
    if (bus.fifo_read_enable !== 1'b0) begin
      bad++;
      $display("FAIL read_in_reset: got en=%b, need 0", bus.fifo_read_enable);
    end
    @(negedge clock);
    check_quiet("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    pl_q = '{16'h00A1, 16'h00A2, 16'h00A3};
    add_frame(16'h0003, 3);
    run_stream(0, 100, 1, 1);
  endtask

  task automatic test_zero_len();
    pl_q.delete();
    add_frame(16'h0000, 0);
    pl_q = '{16'h0055};
    add_frame(16'h0001, 1);
    run_stream(0, 100, 1, 1);
  endtask

  task automatic test_oversize();
    fill_rand(1025);
    add_frame(16'h0401, 1025);
    pl_q = '{16'hBEEF};
    add_frame(16'h0001, 1);
    run_stream(0, 5000, 0, 0);
`ifdef FIFO_FRAME_READER_FRAME_COUNT_EN
    total++;
    if (frame_count !== 32'd4 || drop_count !== 16'd1) begin
      bad++;
      $display("FAIL counters: got frames=%0d drops=%0d, need 4 and 1", frame_count, drop_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    fill_rand(8);
    add_frame(16'h0008, 8);
    run_stream(1, 200, 0, 1);
  endtask

  task automatic test_starve();
    fill_rand(5);
    add_frame(16'h0005, 2);
    fork
      run_stream(0, 200, 0, 1);
      begin
        repeat (10) @(negedge clock);
        for (int i = 0; i < 9; i++) begin
          @(negedge clock);
          total++;
          if (bus.stream_valid !== 1'b0) begin
            bad++;
            $display("FAIL starve_valid: got %b, need 0", bus.stream_valid);
          end
        end
        @(negedge clock);
        flush_pend();
      end
    join
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 6);
      fill_rand(n);
      add_frame({4'($urandom), 12'(n)}, n);
    end
    run_stream(2, 1000, 0, 1);
  endtask

  task automatic test_reset_mid();
    int seen;
    bit hit;
    fill_rand(5);
    add_frame(16'h0005, 5);
    bus.stream_ready = 1'b1;
    seen = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clock);
      if (bus.stream_valid) seen++;
      if (seen == 3) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_payload: got %0d transfers, need 3", seen);
    end
    @(negedge clock);
    reset = 1'b1;
    bus.stream_ready = 1'b0;
    @(negedge clock);
    check_quiet("reset_mid_frame");
    reset = 1'b0;
    exp_q.delete();
    exp_err = 0;
    pl_q = '{16'h1234};
    add_frame(16'h0001, 1);
    run_stream(0, 100, 1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_oversize();
    test_backpressure();
    test_starve();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
